// File: rtl/bp_fpga_host_io_out_axis.sv
// AXI4 slave that turns single-beat I/O-out writes into NBF packets
// {opcode, addr, data}. Each packet is streamed to the host FIFO one flit at a
// time, lowest flit first. The B response is held back until the host has
// taken the last flit. Reads are completed with SLVERR and zero data.
module bp_fpga_host_io_out_axis #(
  parameter int unsigned S_AXI_ADDR_WIDTH   = 64,
  parameter int unsigned S_AXI_DATA_WIDTH   = 64,
  parameter int unsigned S_AXI_ID_WIDTH     = 4,
  parameter int unsigned fifo_data_width_p  = 32,
  parameter int unsigned nbf_opcode_width_p = 8,
  parameter int unsigned nbf_addr_width_p   = 64,
  parameter int unsigned nbf_data_width_p   = 64
) (
  input  logic                          clk,
  input  logic                          reset,

  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_awid,
  input  logic [7:0]                    s_axi_awlen,
  input  logic [2:0]                    s_axi_awsize,
  input  logic [1:0]                    s_axi_awburst,

  input  logic [S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                          s_axi_wlast,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,

  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,

  input  logic [S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  input  logic [S_AXI_ID_WIDTH-1:0]     s_axi_arid,
  input  logic [7:0]                    s_axi_arlen,
  input  logic [2:0]                    s_axi_arsize,
  input  logic [1:0]                    s_axi_arburst,

  output logic [S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rlast,
  output logic [S_AXI_ID_WIDTH-1:0]     s_axi_rid,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready,

  output logic                          fifo_v_o,
  output logic [fifo_data_width_p-1:0]  fifo_data_o,
  input  logic                          fifo_ready_and_i
);

  localparam int unsigned PKT_W  = nbf_opcode_width_p + nbf_addr_width_p + nbf_data_width_p;
  localparam int unsigned FLIT_N = (PKT_W + fifo_data_width_p - 1) / fifo_data_width_p;
  localparam int unsigned PAD_W  = FLIT_N * fifo_data_width_p;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned BEAT_W = 9;
  localparam int unsigned BYTES  = S_AXI_DATA_WIDTH / 8;

  typedef enum logic [2:0] {
    e_idle,
    e_wdata,
    e_send,
    e_bresp,
    e_rresp
  } state_e;

  state_e state_q, state_d;

  logic [S_AXI_ID_WIDTH-1:0]   id_q;
  logic [S_AXI_ADDR_WIDTH-1:0] addr_q;
  logic [2:0]                  size_q;
  logic                        err_q;
  logic                        first_q;
  logic [BEAT_W-1:0]           beats_q;
  logic [CNT_W-1:0]            flit_cnt_q;
  logic [PAD_W-1:0]            pkt_q;

  logic [S_AXI_DATA_WIDTH-1:0] shifted;
  logic [S_AXI_DATA_WIDTH-1:0] kept;
  logic [BYTES-1:0]            byte_keep;
  logic [PAD_W-1:0]            pkt_d;
  logic [fifo_data_width_p-1:0] flit;

  logic aw_hs, w_hs, ar_hs, r_hs, fifo_hs, flit_last;

  assign aw_hs     = s_axi_awvalid & s_axi_awready;
  assign w_hs      = s_axi_wvalid & s_axi_wready;
  assign ar_hs     = s_axi_arvalid & s_axi_arready;
  assign r_hs      = s_axi_rvalid & s_axi_rready;
  assign fifo_hs   = fifo_v_o & fifo_ready_and_i;
  assign flit_last = (flit_cnt_q == CNT_W'(FLIT_N - 1));

  // Strobes and the sideband fields this endpoint does not act on.
  logic unused_inputs;
  assign unused_inputs = ^{s_axi_wstrb, s_axi_awburst, s_axi_araddr, s_axi_arsize, s_axi_arburst};

  // Align the payload to byte 0 and clear the bytes beyond the access size.
  always_comb begin
    shifted   = s_axi_wdata >> {addr_q[2:0], 3'b000};
    byte_keep = '0;
    case (size_q)
      3'd0:    byte_keep = BYTES'(8'h01);
      3'd1:    byte_keep = BYTES'(8'h03);
      3'd2:    byte_keep = BYTES'(8'h0f);
      default: byte_keep = '1;
    endcase
    kept = '0;
    for (int unsigned b = 0; b < BYTES; b++) begin
      kept[b*8 +: 8] = byte_keep[b] ? shifted[b*8 +: 8] : 8'h00;
    end
    pkt_d = PAD_W'({nbf_opcode_width_p'(size_q),
                    nbf_addr_width_p'(addr_q),
                    nbf_data_width_p'(kept)});
  end

  // Select the flit currently offered to the host.
  always_comb begin
    flit = '0;
    for (int unsigned k = 0; k < FLIT_N; k++) begin
      if (flit_cnt_q == CNT_W'(k)) flit = pkt_q[k*fifo_data_width_p +: fifo_data_width_p];
    end
  end

  assign fifo_data_o = (!reset && state_q == e_send) ? flit : '0;
  assign s_axi_rdata = '0;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= e_idle;
    else       state_q <= state_d;
  end

  // Next state and handshake outputs; everything is held low during reset.
  always_comb begin
    state_d       = state_q;
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_bresp   = 2'b00;
    s_axi_bid     = '0;
    s_axi_rvalid  = 1'b0;
    s_axi_rresp   = 2'b00;
    s_axi_rlast   = 1'b0;
    s_axi_rid     = '0;
    fifo_v_o      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        e_idle: begin
          s_axi_awready = 1'b1;
          s_axi_arready = !s_axi_awvalid;
          if (s_axi_awvalid)      state_d = e_wdata;
          else if (s_axi_arvalid) state_d = e_rresp;
        end
        e_wdata: begin
          s_axi_wready = 1'b1;
          if (s_axi_wvalid && s_axi_wlast) state_d = err_q ? e_bresp : e_send;
        end
        e_send: begin
          fifo_v_o = 1'b1;
          if (fifo_ready_and_i && flit_last) state_d = e_bresp;
        end
        e_bresp: begin
          s_axi_bvalid = 1'b1;
          s_axi_bid    = id_q;
          s_axi_bresp  = err_q ? 2'b10 : 2'b00;
          if (s_axi_bready) state_d = e_idle;
        end
        e_rresp: begin
          s_axi_rvalid = 1'b1;
          s_axi_rresp  = 2'b10;
          s_axi_rid    = id_q;
          s_axi_rlast  = (beats_q == BEAT_W'(1));
          if (s_axi_rready && beats_q == BEAT_W'(1)) state_d = e_idle;
        end
        default: state_d = e_idle;
      endcase
    end
  end

  // Transaction context, packet capture, flit and read-beat counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      id_q       <= '0;
      addr_q     <= '0;
      size_q     <= '0;
      err_q      <= 1'b0;
      first_q    <= 1'b0;
      beats_q    <= '0;
      flit_cnt_q <= '0;
      pkt_q      <= '0;
    end else begin
      if (aw_hs) begin
        id_q    <= s_axi_awid;
        addr_q  <= s_axi_awaddr;
        size_q  <= s_axi_awsize;
        err_q   <= (s_axi_awlen != 8'd0);
        first_q <= 1'b1;
      end else if (ar_hs) begin
        id_q    <= s_axi_arid;
        beats_q <= BEAT_W'(s_axi_arlen) + BEAT_W'(1);
      end
      if (w_hs && first_q) begin
        pkt_q   <= pkt_d;
        first_q <= 1'b0;
      end
      if (fifo_hs) flit_cnt_q <= flit_last ? '0 : flit_cnt_q + CNT_W'(1);
      if (r_hs)    beats_q    <= beats_q - BEAT_W'(1);
    end
  end

endmodule

// File: tb/tb_bp_fpga_host_io_out_axis.sv
// Randomised scoreboard bench for bp_fpga_host_io_out_axis (32-bit host flits).
module tb_bp_fpga_host_io_out_axis;

  localparam int unsigned FW  = 32;
  localparam int unsigned NF  = (136 + FW - 1) / FW;
  localparam int          TMO = 300;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [63:0] awaddr = '0;  logic awvalid = 1'b0; logic awready;
  logic [3:0]  awid = '0;    logic [7:0] awlen = '0; logic [2:0] awsize = '0; logic [1:0] awburst = 2'b01;
  logic [63:0] wdata = '0;   logic [7:0] wstrb = '1; logic wlast = 1'b0; logic wvalid = 1'b0; logic wready;
  logic [3:0]  bid;          logic [1:0] bresp; logic bvalid; logic bready = 1'b1;
  logic [63:0] araddr = '0;  logic arvalid = 1'b0; logic arready;
  logic [3:0]  arid = '0;    logic [7:0] arlen = '0; logic [2:0] arsize = 3'd3; logic [1:0] arburst = 2'b01;
  logic [63:0] rdata;        logic [1:0] rresp; logic rlast; logic [3:0] rid; logic rvalid; logic rready = 1'b1;
  logic          fifo_v;
  logic [FW-1:0] fifo_data;
  logic          fifo_ready = 1'b1;

  bp_fpga_host_io_out_axis #(.fifo_data_width_p(FW)) dut (
    .clk(clk), .reset(reset),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready), .s_axi_awid(awid),
    .s_axi_awlen(awlen), .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready), .s_axi_arid(arid),
    .s_axi_arlen(arlen), .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast), .s_axi_rid(rid),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .fifo_v_o(fifo_v), .fifo_data_o(fifo_data), .fifo_ready_and_i(fifo_ready)
  );

  int checks = 0;
  int errors = 0;
  logic [FW-1:0] exp_flits[$];
  logic [5:0]    exp_b[$];
  logic [70:0]   exp_r[$];
  int flits_seen = 0, b_seen = 0, r_seen = 0;
  bit rand_ready = 1'b0;
  logic rdy_pat[$];
  logic brdy_pat[$];

  function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  function automatic void fail_tmo(input string name);
    checks++;
    errors++;
    $display("FAIL %s timeout", name);
  endfunction

  // Reference packet: {opcode, addr, data}, padded to NF flits.
  function automatic logic [NF*FW-1:0] model_pkt(input logic [63:0] addr, input logic [2:0] size,
                                                  input logic [63:0] wd);
    logic [63:0] d;
    int nbytes;
    d = wd >> (8 * addr[2:0]);
    nbytes = 1 << size;
    if (nbytes < 8) d = d & ((64'd1 << (8 * nbytes)) - 64'd1);
    return (NF*FW)'({5'd0, size, addr, d});
  endfunction

  function automatic void expect_write(input logic [3:0] id, input logic [63:0] addr, input logic [2:0] size,
                                       input logic [7:0] len, input logic [63:0] wd);
    logic [NF*FW-1:0] p;
    if (len == 8'd0) begin
      p = model_pkt(addr, size, wd);
      for (int k = 0; k < NF; k++) exp_flits.push_back(p[k*FW +: FW]);
      exp_b.push_back({id, 2'b00});
    end else begin
      exp_b.push_back({id, 2'b10});
    end
  endfunction

  function automatic void expect_read(input logic [3:0] id, input logic [7:0] len);
    for (int k = 0; k <= int'(len); k++) exp_r.push_back({id, 2'b10, (k == int'(len)), 64'd0});
  endfunction

  function automatic int counter(input int which);
    if (which == 0) return flits_seen;
    if (which == 1) return b_seen;
    return r_seen;
  endfunction

  task automatic wait_count(input string name, input int which, input int target);
    int n;
    n = 0;
    while (counter(which) < target) begin
      @(negedge clk); #1;
      n++;
      if (n > TMO) begin fail_tmo(name); return; end
    end
  endtask

  task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [2:0] size,
                           input logic [7:0] len, input logic [63:0] wd, input bit wait_b);
    int n, base;
    bit ok;
    base = b_seen;
    @(posedge clk); #1;
    awid = id; awaddr = addr; awsize = size; awlen = len; awvalid = 1'b1;
    n = 0; ok = 1'b1;
    do begin
      @(negedge clk); n++;
      if (n > TMO) begin fail_tmo("aw_handshake"); ok = 1'b0; end
    end while (!awready && ok);
    @(posedge clk); #1;
    awvalid = 1'b0;
    for (int b = 0; b <= int'(len) && ok; b++) begin
      wdata = (b == 0) ? wd : {$urandom, $urandom};
      wlast = (b == int'(len));
      wvalid = 1'b1;
      n = 0;
      do begin
        @(negedge clk); n++;
        if (n > TMO) begin fail_tmo("w_handshake"); ok = 1'b0; end
      end while (!wready && ok);
      @(posedge clk); #1;
      wvalid = 1'b0; wlast = 1'b0;
    end
    if (wait_b && ok) wait_count("b_wait", 1, base + 1);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [7:0] len, input bit wait_r);
    int n, base;
    base = r_seen;
    @(posedge clk); #1;
    arid = id; arlen = len; araddr = {$urandom, $urandom}; arvalid = 1'b1;
    n = 0;
    do begin
      @(negedge clk); n++;
      if (n > TMO) begin fail_tmo("ar_handshake"); arvalid = 1'b0; return; end
    end while (!arready);
    @(posedge clk); #1;
    arvalid = 1'b0;
    if (wait_r) wait_count("r_wait", 2, base + int'(len) + 1);
  endtask

  // Host-side and response-side ready drivers; patterns advance only while the DUT is offering.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_pat.size() > 0 && fifo_v) fifo_ready = rdy_pat.pop_front();
      else fifo_ready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
      if (brdy_pat.size() > 0 && bvalid) bready = brdy_pat.pop_front();
      else bready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
      rready = rand_ready ? ($urandom_range(0, 99) < 60) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall behaviour.
  logic          prev_stall = 1'b0, prev_bstall = 1'b0;
  logic [FW-1:0] prev_data;
  logic [5:0]    prev_b;
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 1'b0; prev_bstall = 1'b0;
      end else begin
        if (prev_stall) check("flit_hold", {fifo_v, fifo_data}, {1'b1, prev_data});
        if (fifo_v && fifo_ready) begin
          if (exp_flits.size() == 0) begin
            checks++; errors++;
            $display("FAIL flit_unexpected actual=%0h required=none", fifo_data);
          end else check("flit", fifo_data, exp_flits.pop_front());
          flits_seen++;
        end
        prev_stall = fifo_v && !fifo_ready;
        prev_data  = fifo_data;

        if (bvalid) check("b_after_flits", exp_flits.size(), 0);
        if (prev_bstall) check("b_hold", {bvalid, bid, bresp}, {1'b1, prev_b});
        if (bvalid && bready) begin
          if (exp_b.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected actual=%0h required=none", {bid, bresp});
          end else check("b_resp", {bid, bresp}, exp_b.pop_front());
          b_seen++;
        end
        prev_bstall = bvalid && !bready;
        prev_b      = {bid, bresp};

        if (rvalid && rready) begin
          if (exp_r.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected actual=%0h required=none", {rid, rresp, rlast, rdata});
          end else check("r_beat", {rid, rresp, rlast, rdata}, exp_r.pop_front());
          r_seen++;
        end

        if (arvalid && arready) check("ar_after_b", exp_b.size(), 0);
        if (awvalid) check("aw_priority", arready, 1'b0);
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] id;
    logic [63:0] a, d;
    logic [2:0] sz;
    logic [7:0] ln;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", {awready, wready, arready, bvalid, rvalid, rlast, fifo_v}, 7'd0);
    check("rst_data", {bresp, rresp, bid, rid, fifo_data}, '0);
    check("rst_rdata", rdata, 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("idle_ready", {arready, wready, fifo_v}, 3'b100);

    // 8-byte write with the host always ready.
    exp_flits.push_back(32'h55667788); exp_flits.push_back(32'h11223344);
    exp_flits.push_back(32'h00101000); exp_flits.push_back(32'h00000000);
    exp_flits.push_back(32'h00000003); exp_b.push_back({4'h5, 2'b00});
    axi_write(4'h5, 64'h0000_0000_0010_1000, 3'd3, 8'd0, 64'h1122334455667788, 1'b1);

    // 1-byte write at byte offset 3.
    exp_flits.push_back(32'h00000041); exp_flits.push_back(32'h00000000);
    exp_flits.push_back(32'h00101003); exp_flits.push_back(32'h00000000);
    exp_flits.push_back(32'h00000000); exp_b.push_back({4'h2, 2'b00});
    axi_write(4'h2, 64'h0000_0000_0010_1003, 3'd0, 8'd0, 64'hA5A5A5A5_41C3D2E1, 1'b1);

    // Host stalls 1-0-0-1 and B is back-pressured for three cycles.
    rdy_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    brdy_pat = '{1'b0, 1'b0, 1'b0, 1'b1};
    expect_write(4'h9, 64'hDEAD_BEEF_0000_0204, 3'd2, 8'd0, 64'h0123_4567_89AB_CDEF);
    axi_write(4'h9, 64'hDEAD_BEEF_0000_0204, 3'd2, 8'd0, 64'h0123_4567_89AB_CDEF, 1'b1);
    rdy_pat.delete(); brdy_pat.delete();

    // Burst write: error response, no flits.
    expect_write(4'h3, 64'h0000_0000_0010_2000, 3'd3, 8'd3, 64'hFFEE_DDCC_BBAA_9988);
    axi_write(4'h3, 64'h0000_0000_0010_2000, 3'd3, 8'd3, 64'hFFEE_DDCC_BBAA_9988, 1'b1);

    // Two-beat read.
    expect_read(4'hC, 8'd1);
    axi_read(4'hC, 8'd1, 1'b1);

    // Simultaneous AW and AR: the write completes before the read is accepted.
    expect_write(4'h7, 64'h0000_0000_0010_1008, 3'd1, 8'd0, 64'h0000_0000_0000_BEEF);
    expect_read(4'hA, 8'd0);
    begin
      int bb, rb;
      bb = b_seen; rb = r_seen;
      fork
        axi_write(4'h7, 64'h0000_0000_0010_1008, 3'd1, 8'd0, 64'h0000_0000_0000_BEEF, 1'b0);
        axi_read(4'hA, 8'd0, 1'b0);
      join
      wait_count("sim_b", 1, bb + 1);
      wait_count("sim_r", 2, rb + 1);
    end

    // Reset after two flits: the partial packet is dropped.
    begin
      int fb;
      expect_write(4'h1, 64'h0000_0000_0010_1000, 3'd3, 8'd0, 64'hCAFE_F00D_1234_5678);
      fb = flits_seen;
      axi_write(4'h1, 64'h0000_0000_0010_1000, 3'd3, 8'd0, 64'hCAFE_F00D_1234_5678, 1'b0);
      wait_count("rst_flits", 0, fb + 2);
      @(posedge clk); #1;
      reset = 1'b1;
      exp_flits.delete(); exp_b.delete();
      @(negedge clk);
      check("rst_mid", {fifo_v, bvalid, fifo_data}, '0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      check("post_rst", {fifo_v, bvalid, rvalid}, 3'd0);
      expect_write(4'h6, 64'h0000_0000_0010_1010, 3'd3, 8'd0, 64'h0F0E_0D0C_0B0A_0908);
      axi_write(4'h6, 64'h0000_0000_0010_1010, 3'd3, 8'd0, 64'h0F0E_0D0C_0B0A_0908, 1'b1);
    end

    // Random traffic with random back-pressure.
    rand_ready = 1'b1;
    for (int t = 0; t < 40; t++) begin
      id = 4'($urandom);
      if ($urandom_range(0, 3) != 0) begin
        a  = {$urandom, $urandom};
        d  = {$urandom, $urandom};
        sz = 3'($urandom_range(0, 3));
        ln = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 3)) : 8'd0;
        expect_write(id, a, sz, ln, d);
        axi_write(id, a, sz, ln, d, 1'b1);
      end else begin
        ln = 8'($urandom_range(0, 3));
        expect_read(id, ln);
        axi_read(id, ln, 1'b1);
      end
    end
    rand_ready = 1'b0;

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("drain", exp_flits.size() + exp_b.size() + exp_r.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
